// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word memory slave with LATENCY wait states.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests raise mem_err and have no effect.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              mis_q, mis_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_q [DEPTH];

    logic misaligned;
    logic commit;
    logic mem_we;
    logic unused_adr;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |mem_adr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Upper address bits wrap away; low bits only matter with the align check.
    assign unused_adr = ^{mem_adr[31:ADDR_W+2], mem_adr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d   = mem_adr[ADDR_W+1:2];
                    wdata_d = mem_write_data;
                    wr_d    = mem_write;
                    mis_d   = misaligned;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit && !mis_q && !wr_q) begin
            rdata_d = mem_q[idx_q];
        end
    end

    // Reset holds state in IDLE, so no commit can reach the array during reset.
    assign mem_we = commit && wr_q && !mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_read_data = rdata_q;
    assign mem_ready     = (state_q == DONE);
    assign mem_busy      = (state_q != IDLE);
    assign mem_err       = (state_q == DONE) && mis_q;

endmodule
